// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
//   Conditional-execution unit of a single-cycle ARM core. It holds the
//   architectural NZCV flag register and evaluates the instruction's
//   condition field against it. The decoder's PC / register / memory write
//   requests are gated here.
//
//   The flag register is split into two fields with separate write enables.
//   {N,Z} is written when FlagW[1] is set, and {C,V} when FlagW[0] is set.
//   Both fields load only when the instruction's own condition passes.
//   CondEx looks only at the registered flags, so an instruction sees the
//   flags left by earlier instructions and never its own ALU result.
//
// Ports
//   CLK       in   1  system clock, rising edge
//   Reset     in   1  asynchronous, active-high; clears the flag register
//   Cond      in   4  instruction condition field (Instr[31:28])
//   ALUFlags  in   4  {N,Z,C,V} produced by the ALU this cycle
//   FlagW     in   2  flag write request: [1] -> N,Z ; [0] -> C,V
//   PCS       in   1  decoder request to write the PC
//   RegW      in   1  decoder register-write request
//   MemW      in   1  decoder memory-write request
//   NoWrite   in   1  compare-class instruction; suppresses RegWrite
//   PCSrc     out  1  PCS & CondEx
//   RegWrite  out  1  RegW & CondEx & ~NoWrite
//   MemWrite  out  1  MemW & CondEx
//   CondEx    out  1  condition passed
//   Flags     out  4  registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module cond_logic #(
    parameter logic [3:0] NONE_COND = 4'b1111
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [1:0] r_flags_nz;   // {N,Z}
    logic [1:0] r_flags_cv;   // {C,V}

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;
    logic w_cond_ex;
    logic w_wr_nz;
    logic w_wr_cv;

    assign w_n = r_flags_nz[1];
    assign w_z = r_flags_nz[0];
    assign w_c = r_flags_cv[1];
    assign w_v = r_flags_cv[0];

    // Signed greater-or-equal after a subtraction: N equals V.
    assign w_ge = (w_n == w_v);

    always_comb begin
        w_cond_ex = 1'b0;
        if (Cond != NONE_COND) begin
            case (Cond)
                4'b0000: w_cond_ex = w_z;                 // EQ
                4'b0001: w_cond_ex = ~w_z;                // NE
                4'b0010: w_cond_ex = w_c;                 // CS/HS
                4'b0011: w_cond_ex = ~w_c;                // CC/LO
                4'b0100: w_cond_ex = w_n;                 // MI
                4'b0101: w_cond_ex = ~w_n;                // PL
                4'b0110: w_cond_ex = w_v;                 // VS
                4'b0111: w_cond_ex = ~w_v;                // VC
                4'b1000: w_cond_ex = w_c & ~w_z;          // HI
                4'b1001: w_cond_ex = ~w_c | w_z;          // LS
                4'b1010: w_cond_ex = w_ge;                // GE
                4'b1011: w_cond_ex = ~w_ge;               // LT
                4'b1100: w_cond_ex = ~w_z & w_ge;         // GT
                4'b1101: w_cond_ex = w_z | ~w_ge;         // LE
                4'b1110: w_cond_ex = 1'b1;                // AL
                default: w_cond_ex = 1'b0;                // never
            endcase
        end
    end

    // A failed condition blocks flag writes as well as the datapath writes.
    assign w_wr_nz = FlagW[1] & w_cond_ex;
    assign w_wr_cv = FlagW[0] & w_cond_ex;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_flags_nz <= 2'b00;
            r_flags_cv <= 2'b00;
        end else begin
            if (w_wr_nz) begin
                r_flags_nz <= ALUFlags[3:2];
            end
            if (w_wr_cv) begin
                r_flags_cv <= ALUFlags[1:0];
            end
        end
    end

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS  & w_cond_ex;
    assign RegWrite = RegW & w_cond_ex & ~NoWrite;
    assign MemWrite = MemW & w_cond_ex;
    assign Flags    = {r_flags_nz, r_flags_cv};

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

  logic       CLK;
  logic       Reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int checks;
  int errors;

  cond_logic dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowr;
    logic       e_condex;
    logic       e_pcsrc;
    logic       e_regwrite;
    logic       e_memwrite;
    logic [3:0] e_flags;   // flags after the clock edge
  } vec_t;

  vec_t vecs[$];

  // ---------------- reference model ----------------
  logic [3:0] mdl_flags;
  logic [3:0] exp_q[$];

  // Conditions come in complementary pairs: even code = base test,
  // odd code = its negation. Code 1111 is the negation of "always".
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [3:0] next_flags(input logic [3:0] f, input logic [3:0] c,
                                            input logic [1:0] w, input logic [3:0] a);
    logic [3:0] r;
    r = f;
    if (cond_pass(c, f)) begin
      if (w[1]) r[3:2] = a[3:2];
      if (w[0]) r[1:0] = a[1:0];
    end
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [1:0] w,
                       input logic p, input logic r, input logic m, input logic nw);
    Cond = c; ALUFlags = a; FlagW = w; PCS = p; RegW = r; MemW = m; NoWrite = nw;
  endtask

  task automatic check_ctrl(input string tag, input logic ce, input logic ps,
                            input logic rw, input logic mw);
    check({tag, ".CondEx"},   {3'b0, CondEx},   {3'b0, ce});
    check({tag, ".PCSrc"},    {3'b0, PCSrc},    {3'b0, ps});
    check({tag, ".RegWrite"}, {3'b0, RegWrite}, {3'b0, rw});
    check({tag, ".MemWrite"}, {3'b0, MemWrite}, {3'b0, mw});
  endtask

  task automatic add_vec(input logic [3:0] c, input logic [3:0] a, input logic [1:0] w,
                         input logic p, input logic r, input logic m, input logic nw,
                         input logic ce, input logic ps, input logic rw, input logic mw,
                         input logic [3:0] fl);
    vec_t v;
    v.cond = c; v.alu = a; v.fw = w; v.pcs = p; v.regw = r; v.memw = m; v.nowr = nw;
    v.e_condex = ce; v.e_pcsrc = ps; v.e_regwrite = rw; v.e_memwrite = mw; v.e_flags = fl;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    check("reset.Flags", Flags, 4'b0000);
    check_ctrl("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    #10;
    Reset = 1'b0;

    //      cond  alu   fw     pcs   regw  memw  nowr  condex pcsrc regwr memwr flags_after
    add_vec(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    add_vec(4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add_vec(4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110);
    add_vec(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
    add_vec(4'h8, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    add_vec(4'hE, 4'h9, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010);
    add_vec(4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    add_vec(4'hB, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010);
    add_vec(4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    add_vec(4'h0, 4'hF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add_vec(4'hE, 4'h4, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
    add_vec(4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    add_vec(4'hF, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
    add_vec(4'hE, 4'hF, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0111);
    add_vec(4'hC, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111);
    add_vec(4'hD, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);

    foreach (vecs[i]) begin
      drive(vecs[i].cond, vecs[i].alu, vecs[i].fw, vecs[i].pcs,
            vecs[i].regw, vecs[i].memw, vecs[i].nowr);
      @(negedge CLK);
      check_ctrl($sformatf("vec%0d", i), vecs[i].e_condex, vecs[i].e_pcsrc,
                 vecs[i].e_regwrite, vecs[i].e_memwrite);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d.Flags", i), Flags, vecs[i].e_flags);
    end

    // Asynchronous reset between edges with a flag write pending.
    drive(4'hE, 4'h5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst.Flags", Flags, 4'b0000);
    Cond = 4'hF;
    #1;
    check("async_rst.nv_CondEx", {3'b0, CondEx}, 4'b0000);
    Cond = 4'h0;
    #1;
    check("async_rst.EQ_CondEx", {3'b0, CondEx}, 4'b0000);
    Cond = 4'hE;
    #1;
    check("async_rst.RegWrite", {3'b0, RegWrite}, 4'b0001);
    @(posedge CLK);
    #1;
    check("async_rst.hold_Flags", Flags, 4'b0000);
    Reset = 1'b0;
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    mdl_flags = 4'b0000;

    // Randomised run against the reference model, with occasional
    // asynchronous reset pulses between edges.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] c;
      logic       ce;
      c = 4'($urandom_range(0, 15));
      drive(c, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        #1;
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        mdl_flags = 4'b0000;
      end
      @(negedge CLK);
      ce = cond_pass(Cond, mdl_flags);
      check("rnd.CondEx",   {3'b0, CondEx},   {3'b0, ce});
      check("rnd.PCSrc",    {3'b0, PCSrc},    {3'b0, PCS & ce});
      check("rnd.RegWrite", {3'b0, RegWrite}, {3'b0, RegW & ce & !NoWrite});
      check("rnd.MemWrite", {3'b0, MemWrite}, {3'b0, MemW & ce});
      exp_q.push_back(next_flags(mdl_flags, Cond, FlagW, ALUFlags));
      @(posedge CLK);
      #1;
      mdl_flags = exp_q.pop_front();
      check("rnd.Flags", Flags, mdl_flags);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register, loaded from the ALU's `ALUFlags` output under decoder-supplied write enables.
- Evaluates the 4-bit ARM condition field against the stored flags and gates the PCSrc, RegWrite and MemWrite controls.
- Sits between the control decoder / ALU and the datapath write-enables of the single-cycle ARM processor.

Parameters:
- NONE_COND, 4'b1111, cond encoding treated as never-execute (CondEx=0).

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears flag register.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle.
- FlagW  input  2  flag write request from decoder; [1] = N,Z; [0] = C,V.
- PCS  input  1  decoder request to write PC (branch or Rd=PC).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  compare-class instruction (CMP/CMN); suppresses RegWrite.
- PCSrc  output  1  PCS & CondEx.
- RegWrite  output  1  RegW & CondEx & ~NoWrite.
- MemWrite  output  1  MemW & CondEx.
- CondEx  output  1  condition-passed indicator.
- Flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset asserted (any time, no clock needed): Flags=4'b0000.
  - Outputs remain combinational on the cleared flags.
  - Reset mid-instruction discards any pending flag write.
- Flag register, two independent 2-bit fields updated at the rising CLK edge:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondEx.
  - Otherwise each field holds its value.
- CondEx is combinational from Cond and the registered Flags, i.e. the flags left by previous instructions, never the current ALUFlags. A flag write is visible to the next instruction only: one-cycle latency.
- Condition decode (N,Z,C,V = Flags[3..0]):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0
- Failed condition (CondEx=0): PCSrc, RegWrite and MemWrite are all 0, and no flag field updates.
- FlagW=2'b11 with CondEx=1: both fields load in the same edge.
- FlagW=2'b10 (logical ops): C and V are preserved.
- NoWrite=1 with RegW=1: RegWrite=0; flags still update per FlagW.
- Control outputs have no X propagation: any X-free input vector yields defined outputs.

Test Plan:
- Reset high, then low, Cond=1110, RegW=1 -> Flags=0000, CondEx=1, RegWrite=1; Cond=0000 -> CondEx=0, RegWrite=0.
- ALUFlags=0110 (0x10000000+0xF0000000), FlagW=11, Cond=1110, one edge -> Flags=0110; next cycle Cond=0000 (EQ) -> CondEx=1; Cond=1000 (HI) -> CondEx=0.
- Flags=0110, ALUFlags=1001, FlagW=10 -> after edge Flags=1010; C,V retained; Cond=1010 (GE) -> CondEx=0, Cond=1011 (LT) -> CondEx=1.
- Flags=0000, Cond=0000 (fails), FlagW=11, ALUFlags=1111, PCS=1, MemW=1 -> PCSrc=0, MemWrite=0, Flags stays 0000 after edge.
- NoWrite=1, RegW=1, FlagW=11, Cond=1110, ALUFlags=0100 (CMP equal) -> RegWrite=0, Flags=0100 after edge; next Cond=0001 (NE) -> CondEx=0.
- Flags=1111, assert Reset between clock edges -> Flags=0000 immediately; Cond=1111 -> CondEx=0 for any Flags.
